// File: rtl/mux_2x1.sv
// 2:1 multiplexer with a combinational output and a registered shadow stage.
// Optional saturating select-toggle counter enabled by MUX_2X1_TOGGLE_CNT_EN.
module mux_2x1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sel,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] F_q,
`ifdef MUX_2X1_TOGGLE_CNT_EN
  output logic [CNT_W-1:0] sel_toggles,
`endif
  output logic             sel_q
);

  // No handshake: inputs may change at any time; registers capture whatever is present at the edge.
  assign F = sel ? B : A;

  always_ff @(posedge clk) begin
    if (rst) begin
      F_q   <= '0;
      sel_q <= 1'b0;
    end else begin
      F_q   <= F;
      sel_q <= sel;
    end
  end

`ifdef MUX_2X1_TOGGLE_CNT_EN
  // Counts edges where sel differs from its registered copy; holds at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_toggles <= '0;
    end else if ((sel != sel_q) && (sel_toggles != {CNT_W{1'b1}})) begin
      sel_toggles <= sel_toggles + 1'b1;
    end
  end
`else
  // CNT_W only shapes the counter; keep an empty reference so the parameter stays bound.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_mux_2x1.sv
// Self-checking bench for mux_2x1: one WIDTH=1/CNT_W=2 instance and one WIDTH=8 instance.
module tb_mux_2x1;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic       sel = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       f1, fq1, selq1;
  logic [7:0] f8, fq8;
  logic       selq8;
  logic [1:0] tog1;
  logic [7:0] tog8;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic       m_fq1, m_selq;
  logic [7:0] m_fq8;
  int         m_tog1, m_tog8;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  mux_2x1 #(.WIDTH(1), .CNT_W(2)) u_w1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .sel(sel),
    .F(f1), .F_q(fq1),
`ifdef MUX_2X1_TOGGLE_CNT_EN
    .sel_toggles(tog1),
`endif
    .sel_q(selq1)
  );

  mux_2x1 #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .sel(sel),
    .F(f8), .F_q(fq8),
`ifdef MUX_2X1_TOGGLE_CNT_EN
    .sel_toggles(tog8),
`endif
    .sel_q(selq8)
  );

`ifndef MUX_2X1_TOGGLE_CNT_EN
  assign tog1 = '0;
  assign tog8 = '0;
`endif

  // Reference: the select bit is an index into the pair of inputs.
  function automatic logic [7:0] ref_pick(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [7:0] ins [2];
    ins[0] = a;
    ins[1] = b;
    return ins[int'(s)];
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_fq1 = 1'b0; m_fq8 = '0; m_selq = 1'b0; m_tog1 = 0; m_tog8 = 0;
    end else begin
      if (sel !== m_selq) begin
        m_tog1 = sat_inc(m_tog1, 3);
        m_tog8 = sat_inc(m_tog8, 255);
      end
      m_fq1  = ref_pick({7'd0, a1}, {7'd0, b1}, sel) != 8'd0;
      m_fq8  = ref_pick(a8, b8, sel);
      m_selq = sel;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb_sweep();
    logic [7:0] tt;
    logic [2:0] v;
    tt = 8'b1101_1000;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, sel} = v;
      #1;
      n_cmp++;
      if (f1 !== tt[i]) begin
        n_bad++;
        $display("FAIL comb_sweep ABsel=%b F=%b expected=%b", v, f1, tt[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; a1 = 1'b1; b1 = 1'b0; sel = 1'b0;
    clk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (fq1 !== 1'b0 || selq1 !== 1'b0 || f1 !== 1'b1 || fq8 !== 8'd0) begin
        n_bad++;
        $display("FAIL reset edge%0d F_q=%b sel_q=%b F=%b F_q8=%h expected 0 0 1 00", k, fq1, selq1, f1, fq8);
      end
`ifdef MUX_2X1_TOGGLE_CNT_EN
      n_cmp++;
      if (tog1 !== 2'd0) begin
        n_bad++;
        $display("FAIL reset_toggles got=%0d expected=0", tog1);
      end
`endif
    end
  endtask

  task automatic test_latency();
    rst = 1'b0; a1 = 1'b1; b1 = 1'b0; sel = 1'b1;
    #1;
    n_cmp++;
    if (f1 !== 1'b0) begin
      n_bad++;
      $display("FAIL latency_comb0 F=%b expected=0", f1);
    end
    tick();
    n_cmp++;
    if (fq1 !== 1'b0 || selq1 !== 1'b1) begin
      n_bad++;
      $display("FAIL latency_edgeN F_q=%b sel_q=%b expected 0 1", fq1, selq1);
    end
    sel = 1'b0;
    #1;
    n_cmp++;
    if (f1 !== 1'b1) begin
      n_bad++;
      $display("FAIL latency_comb1 F=%b expected=1", f1);
    end
    tick();
    n_cmp++;
    if (fq1 !== 1'b1 || selq1 !== 1'b0) begin
      n_bad++;
      $display("FAIL latency_edgeN1 F_q=%b sel_q=%b expected 1 0", fq1, selq1);
    end
  endtask

  task automatic test_wide();
    a8 = 8'hA5; b8 = 8'h3C; sel = 1'b0;
    #1;
    n_cmp++;
    if (f8 !== 8'hA5) begin
      n_bad++;
      $display("FAIL wide_sel0 F=%h expected=a5", f8);
    end
    tick();
    sel = 1'b1;
    #1;
    n_cmp++;
    if (fq8 !== 8'hA5 || f8 !== 8'h3C) begin
      n_bad++;
      $display("FAIL wide_sel1 F_q=%h F=%h expected a5 3c", fq8, f8);
    end
    tick();
    n_cmp++;
    if (fq8 !== 8'h3C) begin
      n_bad++;
      $display("FAIL wide_fq F_q=%h expected=3c", fq8);
    end
  endtask

  task automatic test_toggle_sat();
`ifdef MUX_2X1_TOGGLE_CNT_EN
    int expv [5];
    expv = '{1, 2, 3, 3, 3};
    rst = 1'b1; sel = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sel = ~sel;
      tick();
      n_cmp++;
      if (tog1 !== 2'(expv[k])) begin
        n_bad++;
        $display("FAIL toggle_sat edge%0d got=%0d expected=%0d", k, tog1, expv[k]);
      end
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (tog1 !== 2'd0) begin
      n_bad++;
      $display("FAIL toggle_reset got=%0d expected=0", tog1);
    end
    rst = 1'b0;
`endif
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 4; k++) begin
      sel = 1'($urandom_range(0, 1)); a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
      tick();
    end
    sel = 1'b1; a1 = 1'b0; b1 = 1'b1; rst = 1'b1;
    #1;
    n_cmp++;
    if (f1 !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_comb_before F=%b expected=1", f1);
    end
    tick();
    n_cmp++;
    if (fq1 !== 1'b0 || selq1 !== 1'b0 || f1 !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset F_q=%b sel_q=%b F=%b expected 0 0 1", fq1, selq1, f1);
    end
`ifdef MUX_2X1_TOGGLE_CNT_EN
    n_cmp++;
    if (tog1 !== 2'd0) begin
      n_bad++;
      $display("FAIL midreset_toggles got=%0d expected=0", tog1);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] e8;
    for (int k = 0; k < 300; k++) begin
      rst = ($urandom_range(0, 19) == 0);
      sel = 1'($urandom_range(0, 1));
      a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
      a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
      #1;
      e8 = ref_pick(a8, b8, sel);
      n_cmp++;
      if (f8 !== e8 || f1 !== (ref_pick({7'd0, a1}, {7'd0, b1}, sel) != 8'd0)) begin
        n_bad++;
        $display("FAIL random_comb it%0d F8=%h exp=%h F1=%b", k, f8, e8, f1);
      end
      tick();
      n_cmp++;
      if (fq1 !== m_fq1 || fq8 !== m_fq8 || selq1 !== m_selq || selq8 !== m_selq) begin
        n_bad++;
        $display("FAIL random_reg it%0d F_q1=%b/%b F_q8=%h/%h sel_q=%b/%b (got/exp)",
                 k, fq1, m_fq1, fq8, m_fq8, selq1, m_selq);
      end
`ifdef MUX_2X1_TOGGLE_CNT_EN
      n_cmp++;
      if (tog1 !== 2'(m_tog1) || tog8 !== 8'(m_tog8)) begin
        n_bad++;
        $display("FAIL random_toggles it%0d tog1=%0d/%0d tog8=%0d/%0d (got/exp)", k, tog1, m_tog1, tog8, m_tog8);
      end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    test_comb_sweep();
    test_reset();
    test_latency();
    test_wide();
    test_toggle_sat();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
